// File: rtl/mem_bridge.sv
// rtl/mem_bridge.sv - CPU memory-port bridge: word RAM, UART TX FIFO and cycle counter
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   cpu_addr      byte address from the CPU, bits [1:0] ignored
//   cpu_wdata     store data from the CPU
//   cpu_rw        1 = write, 0 = read (held by the CPU for the whole access)
//   cpu_rdata     registered read data, one clock after the address
//   uart_tx       serial output, idle high
//   irq_tx_empty  high while the TX FIFO is empty and the shifter is idle
//
// Optional feature: define MEM_BRIDGE_CYCLE_CNT_EN to build the CYCLE register
// at MMIO offset 0x08; without it that offset reads 0 and ignores writes.
module mem_bridge #(
    parameter int         RAM_WORDS     = 4096,
    parameter logic [3:0] MMIO_BASE_NIB = 4'hF,
    parameter int         CLK_DIV       = 434,
    parameter int         FIFO_DEPTH    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_rw,
    output logic [31:0] cpu_rdata,
    output logic        uart_tx,
    output logic        irq_tx_empty
);

    localparam int RAW = $clog2(RAM_WORDS);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BW  = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_LAST     = BW'(CLK_DIV - 1);
    localparam logic [8:0]    FIFO_FULL_CNT = 9'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    logic [31:0]   ram [RAM_WORDS];
    logic [7:0]    fifo_mem [FIFO_DEPTH];

    logic          rw_q;
    logic [29:0]   addr_q;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [8:0]    fifo_count;
    logic          overflow;

    tx_state_t     tx_state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shifter;

    logic          is_mmio;
    logic [RAW-1:0] ram_idx;
    logic [5:0]    mmio_reg;
    logic          commit;
    logic          ram_we;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          status_we;
    logic          fifo_full;
    logic          fifo_empty;
    logic [31:0]   status_word;
    logic [31:0]   cycle_rd;
    logic [31:0]   mmio_rdata;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr[1:0];

    assign is_mmio  = (cpu_addr[31:28] == MMIO_BASE_NIB);
    assign ram_idx  = cpu_addr[RAW+1:2];
    assign mmio_reg = cpu_addr[7:2];

    // A store is held for several clocks; only its first cycle (or a change of
    // word address while still writing) is allowed to have side effects.
    assign commit    = cpu_rw && (!rw_q || (cpu_addr[31:2] != addr_q));
    assign ram_we    = commit && !is_mmio;
    assign push_req  = commit && is_mmio && (mmio_reg == 6'h00);
    assign status_we = commit && is_mmio && (mmio_reg == 6'h01);

    assign fifo_full  = (fifo_count == FIFO_FULL_CNT);
    assign fifo_empty = (fifo_count == 9'd0);
    assign pop        = (tx_state == ST_IDLE) && !fifo_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO succeeds.
    assign push_ok    = push_req && (!fifo_full || pop);

    assign status_word = {16'h0000, fifo_count[7:0], 4'h0,
                          overflow, (tx_state != ST_IDLE), fifo_empty, fifo_full};

`ifdef MEM_BRIDGE_CYCLE_CNT_EN
    logic [31:0] cycle_cnt;
    logic        cycle_we;

    assign cycle_we = commit && is_mmio && (mmio_reg == 6'h02);
    assign cycle_rd = cycle_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= 32'h0;
        end else if (cycle_we) begin
            cycle_cnt <= cpu_wdata;
        end else begin
            cycle_cnt <= cycle_cnt + 32'h1;
        end
    end
`else
    assign cycle_rd = 32'h0;
`endif

    always_comb begin
        mmio_rdata = 32'h0;
        case (mmio_reg)
            6'h01:   mmio_rdata = status_word;
            6'h02:   mmio_rdata = cycle_rd;
            default: mmio_rdata = 32'h0;
        endcase
    end

    // Storage arrays carry no reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= cpu_wdata;
        end
        if (push_ok) begin
            fifo_mem[wr_ptr] <= cpu_wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rdata    <= 32'h0;
            rw_q         <= 1'b0;
            addr_q       <= 30'h0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= 9'd0;
            overflow     <= 1'b0;
            irq_tx_empty <= 1'b1;
            uart_tx      <= 1'b1;
            tx_state     <= ST_IDLE;
            baud_cnt     <= '0;
            bit_idx      <= 3'd0;
            shifter      <= 8'h00;
        end else begin
            // Old RAM word is returned when a write hits the same index this cycle.
            cpu_rdata <= is_mmio ? mmio_rdata : ram[ram_idx];
            rw_q      <= cpu_rw;
            addr_q    <= cpu_addr[31:2];

            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 9'd1;
                2'b01:   fifo_count <= fifo_count - 9'd1;
                default: fifo_count <= fifo_count;
            endcase

            overflow <= (overflow && !(status_we && cpu_wdata[3])) ||
                        (push_req && !push_ok);

            irq_tx_empty <= fifo_empty && (tx_state == ST_IDLE);

            case (tx_state)
                ST_IDLE: begin
                    uart_tx <= 1'b1;
                    if (pop) begin
                        shifter  <= fifo_mem[rd_ptr];
                        baud_cnt <= BAUD_LAST;
                        uart_tx  <= 1'b0;
                        tx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_cnt == '0) begin
                        uart_tx  <= shifter[0];
                        shifter  <= {1'b0, shifter[7:1]};
                        bit_idx  <= 3'd0;
                        baud_cnt <= BAUD_LAST;
                        tx_state <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_LAST;
                        if (bit_idx == 3'd7) begin
                            uart_tx  <= 1'b1;
                            tx_state <= ST_STOP;
                        end else begin
                            uart_tx <= shifter[0];
                            shifter <= {1'b0, shifter[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_cnt == '0) begin
                        tx_state <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: begin
                    uart_tx  <= 1'b1;
                    tx_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// tb/tb_mem_bridge.sv - directed self-checking bench for mem_bridge
module tb_mem_bridge;

    localparam logic [31:0] A_TX   = 32'hF000_0000;
    localparam logic [31:0] A_STAT = 32'hF000_0004;
    localparam logic [31:0] A_CYC  = 32'hF000_0008;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] cpu_addr = 32'h0;
    logic [31:0] cpu_wdata = 32'h0;
    logic        cpu_rw = 1'b0;
    logic [31:0] cpu_rdata;
    logic        uart_tx;
    logic        irq_tx_empty;

    int tests = 0;
    int fails = 0;

    logic [7:0] rx_q[$];
    logic       mon_en = 1'b1;

    always #5 clk = ~clk;

    mem_bridge #(
        .RAM_WORDS    (4096),
        .MMIO_BASE_NIB(4'hF),
        .CLK_DIV      (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rw      (cpu_rw),
        .cpu_rdata   (cpu_rdata),
        .uart_tx     (uart_tx),
        .irq_tx_empty(irq_tx_empty)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input int n);
        @(negedge clk);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_rw    = 1'b1;
        repeat (n) @(negedge clk);
        cpu_rw = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        cpu_addr = a;
        cpu_rw   = 1'b0;
        @(negedge clk);
        d = cpu_rdata;
    endtask

    task automatic wait_irq(input int max, input string tag);
        int n = 0;
        while (irq_tx_empty !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'h0, irq_tx_empty}, 32'h1);
    endtask

    // Serial receiver: samples mid-bit at CLK_DIV=4 and queues received bytes.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && uart_tx === 1'b0) begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (4) @(negedge clk);
                check("rx_stop", {31'h0, uart_tx}, 32'h1);
                rx_q.push_back(b);
            end
        end
    end

    initial begin
        logic [31:0] d;
        logic [3:0]  seen;
        logic [9:0]  frame;
        int          n;

        // Reset with random inputs
        repeat (3) begin
            @(negedge clk);
            cpu_addr  = $urandom;
            cpu_wdata = $urandom;
            cpu_rw    = 1'($urandom);
        end
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_tx", {31'h0, uart_tx}, 32'h1);
        check("rst_irq", {31'h0, irq_tx_empty}, 32'h1);
        @(negedge clk);
        reset    = 1'b1;
        cpu_rw   = 1'b0;
        cpu_addr = 32'h0;
        rd(A_STAT, d);
        check("rst_status", d, 32'h0000_0002);

        // RAM round trip and aliasing
        wr(32'h0000_0010, 32'hDEAD_BEEF, 2);
        rd(32'h0000_0010, d);
        check("ram_rd", d, 32'hDEAD_BEEF);
        rd(32'h0000_4010, d);
        check("ram_alias", d, 32'hDEAD_BEEF);

        // Read during write to the same index returns the old word
        wr(32'h0000_0020, 32'h1234_5678, 1);
        @(negedge clk);
        cpu_addr  = 32'h0000_0020;
        cpu_wdata = 32'hCAFE_F00D;
        cpu_rw    = 1'b1;
        @(negedge clk);
        check("ram_rdw_old", cpu_rdata, 32'h1234_5678);
        cpu_rw = 1'b0;
        rd(32'h0000_0020, d);
        check("ram_rdw_new", d, 32'hCAFE_F00D);

        // MMIO reads of TX_DATA and unmapped offset return 0
        rd(A_TX, d);
        check("txdata_rd", d, 32'h0);
        rd(32'hF000_0010, d);
        check("unmapped_rd", d, 32'h0);

        // Cycle counter
        wr(A_CYC, 32'h0000_1000, 1);
        rd(A_CYC, d);
`ifdef MEM_BRIDGE_CYCLE_CNT_EN
        check("cycle_load", d, 32'h0000_1001);
`else
        check("cycle_absent", d, 32'h0);
`endif

        // UART frame 0x55: start, LSB-first data, stop, each bit 4 clocks
        frame = {1'b1, 8'h55, 1'b0};
        wr(A_TX, 32'h0000_0055, 1);
        n = 0;
        while (uart_tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("frame_start_seen", {31'h0, uart_tx}, 32'h0);
        for (int bitn = 0; bitn < 10; bitn++) begin
            for (int k = 0; k < 4; k++) begin
                seen[k] = uart_tx;
                if (bitn == 4 && k == 0) check("irq_busy", {31'h0, irq_tx_empty}, 32'h0);
                @(negedge clk);
            end
            check($sformatf("frame_bit%0d", bitn), {28'h0, seen}, {28'h0, {4{frame[bitn]}}});
        end
        wait_irq(10, "irq_after_stop");
        check("rx_55_cnt", rx_q.size(), 32'd1);
        if (rx_q.size() > 0) check("rx_55", {24'h0, rx_q[0]}, 32'h55);
        rx_q.delete();

        // Held store commits once: 0x40 occupies the shifter, 0x41 held 5 clocks
        wr(A_TX, 32'h0000_0040, 1);
        wr(A_TX, 32'h0000_0041, 5);
        rd(A_STAT, d);
        check("held_status", d, 32'h0000_0104);
        wait_irq(200, "held_irq");
        check("held_rx_cnt", rx_q.size(), 32'd2);
        if (rx_q.size() == 2) begin
            check("held_rx0", {24'h0, rx_q[0]}, 32'h40);
            check("held_rx1", {24'h0, rx_q[1]}, 32'h41);
        end
        rx_q.delete();

        // Overflow: 6 pushes, 1 in shifter, 4 queued, 1 dropped
        for (int i = 0; i < 6; i++) wr(A_TX, 32'h61 + i, 1);
        rd(A_STAT, d);
        check("ovf_status", d, 32'h0000_040D);
        wr(A_STAT, 32'h0000_0008, 1);
        rd(A_STAT, d);
        check("ovf_clear", d, 32'h0000_0405);
        wait_irq(400, "ovf_irq");
        check("ovf_rx_cnt", rx_q.size(), 32'd5);
        if (rx_q.size() == 5) begin
            for (int i = 0; i < 5; i++) check($sformatf("ovf_rx%0d", i), {24'h0, rx_q[i]}, 32'h61 + i);
        end
        rx_q.delete();

        // Back-to-back commits with rw held high across an address change
        @(negedge clk);
        cpu_addr  = 32'h0000_0100;
        cpu_wdata = 32'h11;
        cpu_rw    = 1'b1;
        @(negedge clk);
        cpu_addr  = 32'h0000_00FC;
        cpu_wdata = 32'h22;
        @(negedge clk);
        cpu_rw = 1'b0;
        rd(32'h0000_0100, d);
        check("b2b_100", d, 32'h11);
        rd(32'h0000_00FC, d);
        check("b2b_0fc", d, 32'h22);

        // Async reset in the middle of the data bits
        mon_en = 1'b0;
        wr(A_TX, 32'h0000_0000, 1);
        wr(A_TX, 32'h0000_0000, 1);
        repeat (12) @(negedge clk);
        check("pre_rst_tx", {31'h0, uart_tx}, 32'h0);
        #1 reset = 1'b0;
        #1 check("rst_async_tx", {31'h0, uart_tx}, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        rd(A_STAT, d);
        check("rst_fifo_empty", d, 32'h0000_0002);
        check("rst_irq2", {31'h0, irq_tx_empty}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
